// File: rtl/solver_phase_scheduler.sv
// rtl/solver_phase_scheduler.sv - MCMC solver phase sequencer with per-phase done handshakes
// Optional per-phase watchdog enabled by defining SOLVER_PHASE_TIMEOUT_EN.
module solver_phase_scheduler #(
  parameter int ITERATION_WIDTH   = 16,
  parameter int PROBABILITY_WIDTH = 8,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         in_clk,
  input  logic                         in_reset,
  input  logic                         in_start,
  input  logic [ITERATION_WIDTH-1:0]   in_max_iterations,
  input  logic [PROBABILITY_WIDTH-1:0] in_random,
  input  logic [PROBABILITY_WIDTH-1:0] in_probability,
  input  logic                         in_setup_done,
  input  logic                         in_probabilistic_done,
  input  logic                         in_stochastic_done,
  input  logic                         in_adjust_done,
  input  logic                         in_checker_done,
  input  logic                         in_checker_satisfied,
  output logic [7:0]                   out_current_state,
  output logic                         out_busy,
  output logic                         out_done,
  output logic                         out_success,
  output logic [ITERATION_WIDTH-1:0]   out_iteration_count,
  output logic [ITERATION_WIDTH-1:0]   out_stochastic_count,
  output logic                         out_timeout
);

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_SETUP         = 3'd1,
    S_PROBABILISTIC = 3'd2,
    S_STOCHASTIC    = 3'd3,
    S_ADJUST        = 3'd4,
    S_CHECKER       = 3'd5,
    S_FINISH        = 3'd6
  } state_t;

  localparam logic [ITERATION_WIDTH-1:0] CNT_MAX = {ITERATION_WIDTH{1'b1}};

  state_t                       state_q, state_d;
  logic [ITERATION_WIDTH-1:0]   limit_q, limit_d;
  logic [ITERATION_WIDTH-1:0]   iter_q, iter_d;
  logic [ITERATION_WIDTH-1:0]   stoch_q, stoch_d;
  logic                         success_q, success_d;
  logic                         busy_q, done_q;
  logic                         select_stoch;
  logic [ITERATION_WIDTH:0]     iter_next_wide;

  assign select_stoch   = (in_random < in_probability);
  // One extra bit so a saturated count can never alias a nonzero limit.
  assign iter_next_wide = {1'b0, iter_q} + {{ITERATION_WIDTH{1'b0}}, 1'b1};

`ifdef SOLVER_PHASE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            phase_done;

  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      S_SETUP:         phase_done = in_setup_done;
      S_PROBABILISTIC: phase_done = in_probabilistic_done;
      S_STOCHASTIC:    phase_done = in_stochastic_done;
      S_ADJUST:        phase_done = in_adjust_done;
      S_CHECKER:       phase_done = in_checker_done;
      default:         phase_done = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    iter_d    = iter_q;
    stoch_d   = stoch_q;
    success_d = success_q;
`ifdef SOLVER_PHASE_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (in_start) begin
          limit_d   = in_max_iterations;
          iter_d    = '0;
          stoch_d   = '0;
          success_d = 1'b0;
`ifdef SOLVER_PHASE_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (in_setup_done) begin
          if (select_stoch) begin
            state_d = S_STOCHASTIC;
            if (stoch_q != CNT_MAX) stoch_d = stoch_q + 1'b1;
          end else begin
            state_d = S_PROBABILISTIC;
          end
        end
      end
      S_PROBABILISTIC: if (in_probabilistic_done) state_d = S_ADJUST;
      S_STOCHASTIC:    if (in_stochastic_done)    state_d = S_ADJUST;
      S_ADJUST:        if (in_adjust_done)        state_d = S_CHECKER;
      S_CHECKER: begin
        if (in_checker_done) begin
          if (in_checker_satisfied) begin
            state_d   = S_FINISH;
            success_d = 1'b1;
          end else begin
            if (iter_q != CNT_MAX) iter_d = iter_q + 1'b1;
            if (limit_q != '0 && iter_next_wide == {1'b0, limit_q}) begin
              state_d   = S_FINISH;
              success_d = 1'b0;
            end else if (select_stoch) begin
              state_d = S_STOCHASTIC;
              if (stoch_q != CNT_MAX) stoch_d = stoch_q + 1'b1;
            end else begin
              state_d = S_PROBABILISTIC;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SOLVER_PHASE_TIMEOUT_EN
    // Expiry only aborts when the phase's own done is absent, so done wins a tie.
    if (state_q != S_IDLE && state_q != S_FINISH && !phase_done && wd_q == WD_LAST) begin
      state_d   = S_FINISH;
      timeout_d = 1'b1;
      success_d = 1'b0;
    end
    if (state_q == S_IDLE || state_q == S_FINISH || phase_done)
      wd_d = '0;
    else
      wd_d = wd_q + 1'b1;
`endif
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q   <= S_IDLE;
      limit_q   <= '0;
      iter_q    <= '0;
      stoch_q   <= '0;
      success_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      iter_q    <= iter_d;
      stoch_q   <= stoch_d;
      success_q <= success_d;
      busy_q    <= (state_d != S_IDLE) && (state_d != S_FINISH);
      done_q    <= (state_d == S_FINISH);
    end
  end

`ifdef SOLVER_PHASE_TIMEOUT_EN
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign out_timeout        = 1'b0;
`endif

  assign out_current_state    = {5'd0, state_q};
  assign out_busy             = busy_q;
  assign out_done             = done_q;
  assign out_success          = success_q;
  assign out_iteration_count  = iter_q;
  assign out_stochastic_count = stoch_q;

endmodule

// File: tb/tb_solver_phase_scheduler.sv
// tb/tb_solver_phase_scheduler.sv - directed self-checking bench for solver_phase_scheduler
module tb_solver_phase_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] max_it;
  logic [7:0]  rnd, prob;
  logic        setup_done, prob_done, stoch_done, adj_done, chk_done, chk_sat;
  logic [7:0]  state;
  logic        busy, done, success, timeout;
  logic [15:0] iter_cnt, stoch_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  solver_phase_scheduler #(
    .ITERATION_WIDTH(16),
    .PROBABILITY_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .in_clk(clk),
    .in_reset(rst),
    .in_start(start),
    .in_max_iterations(max_it),
    .in_random(rnd),
    .in_probability(prob),
    .in_setup_done(setup_done),
    .in_probabilistic_done(prob_done),
    .in_stochastic_done(stoch_done),
    .in_adjust_done(adj_done),
    .in_checker_done(chk_done),
    .in_checker_satisfied(chk_sat),
    .out_current_state(state),
    .out_busy(busy),
    .out_done(done),
    .out_success(success),
    .out_iteration_count(iter_cnt),
    .out_stochastic_count(stoch_cnt),
    .out_timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dones();
    setup_done = 0; prob_done = 0; stoch_done = 0; adj_done = 0; chk_done = 0; chk_sat = 0;
  endtask

  // Pulse the done input belonging to phase code c for one edge.
  task automatic advance(input int c, input logic sat);
    case (c)
      1: setup_done = 1;
      2: prob_done  = 1;
      3: stoch_done = 1;
      4: adj_done   = 1;
      5: begin chk_done = 1; chk_sat = sat; end
      default: ;
    endcase
    tick();
    clear_dones();
  endtask

  task automatic test_reset();
    rst = 1; start = 0; max_it = 0; rnd = 0; prob = 0; clear_dones();
    tick(); tick();
    rst = 0;
    checks++;
    if ({state, busy, done, success, timeout} !== {8'd0, 4'b0000}) begin
      fails++; $display("FAIL reset_flags: got state=%0d busy=%b done=%b succ=%b to=%b want 0", state, busy, done, success, timeout);
    end
    checks++;
    if ({iter_cnt, stoch_cnt} !== 32'd0) begin
      fails++; $display("FAIL reset_counts: got iter=%0d stoch=%0d want 0", iter_cnt, stoch_cnt);
    end
  endtask

  task automatic test_start_setup();
    max_it = 16'd3; start = 1;
    tick();
    start = 0;
    checks++;
    if (state !== 8'd1 || busy !== 1'b1) begin
      fails++; $display("FAIL start_to_setup: got state=%0d busy=%b want 1 1", state, busy);
    end
    tick(); tick();
    checks++;
    if (state !== 8'd1) begin
      fails++; $display("FAIL setup_wait: got %0d want 1", state);
    end
    rnd = 8'h10; prob = 8'h80;
    advance(1, 0);
    checks++;
    if (state !== 8'd3 || stoch_cnt !== 16'd1) begin
      fails++; $display("FAIL select_stoch: got state=%0d stoch=%0d want 3 1", state, stoch_cnt);
    end
  endtask

  task automatic test_limit_loops();
    advance(2, 0);
    checks++;
    if (state !== 8'd3) begin
      fails++; $display("FAIL ignore_wrong_done: got %0d want 3", state);
    end
    advance(3, 0);
    advance(4, 0);
    checks++;
    if (state !== 8'd5) begin
      fails++; $display("FAIL reach_checker: got %0d want 5", state);
    end
    rnd = 8'h80; prob = 8'h80;
    advance(5, 0);
    checks++;
    if (state !== 8'd2 || iter_cnt !== 16'd1 || stoch_cnt !== 16'd1) begin
      fails++; $display("FAIL select_prob_equal: got state=%0d iter=%0d stoch=%0d want 2 1 1", state, iter_cnt, stoch_cnt);
    end
    advance(2, 0); advance(4, 0);
    rnd = 8'h10;
    advance(5, 0);
    checks++;
    if (state !== 8'd3 || iter_cnt !== 16'd2 || stoch_cnt !== 16'd2) begin
      fails++; $display("FAIL loop2: got state=%0d iter=%0d stoch=%0d want 3 2 2", state, iter_cnt, stoch_cnt);
    end
    advance(3, 0); advance(4, 0); advance(5, 0);
    checks++;
    if (state !== 8'd6 || success !== 1'b0 || iter_cnt !== 16'd3 || done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL limit_finish: got state=%0d succ=%b iter=%0d done=%b busy=%b want 6 0 3 1 0", state, success, iter_cnt, done, busy);
    end
    tick(); tick();
    checks++;
    if (state !== 8'd6 || iter_cnt !== 16'd3) begin
      fails++; $display("FAIL finish_hold: got state=%0d iter=%0d want 6 3", state, iter_cnt);
    end
  endtask

  task automatic test_satisfied();
    max_it = 16'd0; start = 1;
    tick();
    start = 0;
    checks++;
    if (state !== 8'd1 || iter_cnt !== 16'd0 || stoch_cnt !== 16'd0 || done !== 1'b0) begin
      fails++; $display("FAIL restart: got state=%0d iter=%0d stoch=%0d done=%b want 1 0 0 0", state, iter_cnt, stoch_cnt, done);
    end
    rnd = 8'h00; prob = 8'h00;
    advance(1, 0);
    checks++;
    if (state !== 8'd2 || stoch_cnt !== 16'd0) begin
      fails++; $display("FAIL prob_zero: got state=%0d stoch=%0d want 2 0", state, stoch_cnt);
    end
    advance(2, 0); advance(4, 0);
    rnd = 8'hFE; prob = 8'hFF;
    advance(5, 0);
    checks++;
    if (state !== 8'd3 || iter_cnt !== 16'd1 || stoch_cnt !== 16'd1) begin
      fails++; $display("FAIL prob_ones_sel: got state=%0d iter=%0d stoch=%0d want 3 1 1", state, iter_cnt, stoch_cnt);
    end
    advance(3, 0); advance(4, 0); advance(5, 1);
    checks++;
    if (state !== 8'd6 || success !== 1'b1 || iter_cnt !== 16'd1) begin
      fails++; $display("FAIL satisfied: got state=%0d succ=%b iter=%0d want 6 1 1", state, success, iter_cnt);
    end
    start = 1;
    tick();
    start = 0;
    checks++;
    if (state !== 8'd1 || iter_cnt !== 16'd0 || stoch_cnt !== 16'd0 || success !== 1'b0) begin
      fails++; $display("FAIL restart2: got state=%0d iter=%0d stoch=%0d succ=%b want 1 0 0 0", state, iter_cnt, stoch_cnt, success);
    end
    rnd = 8'hFF; prob = 8'hFF;
    advance(1, 0);
    checks++;
    if (state !== 8'd2 || stoch_cnt !== 16'd0) begin
      fails++; $display("FAIL ones_vs_ones: got state=%0d stoch=%0d want 2 0", state, stoch_cnt);
    end
  endtask

  task automatic test_spurious_and_reset();
    adj_done = 1; start = 1;
    tick();
    adj_done = 0; start = 0;
    checks++;
    if (state !== 8'd2) begin
      fails++; $display("FAIL spurious_adjust: got %0d want 2", state);
    end
    advance(2, 0);
    rst = 1; adj_done = 1; start = 1;
    tick();
    rst = 0; adj_done = 0; start = 0;
    checks++;
    if ({state, busy, done, success, timeout, iter_cnt, stoch_cnt} !== 44'd0) begin
      fails++; $display("FAIL midrun_reset: got state=%0d busy=%b done=%b succ=%b to=%b iter=%0d stoch=%0d want all 0", state, busy, done, success, timeout, iter_cnt, stoch_cnt);
    end
  endtask

  task automatic test_timeout();
    max_it = 16'd0; start = 1;
    tick();
    start = 0;
    rnd = 8'h00; prob = 8'h01;
    advance(1, 0);
    checks++;
    if (state !== 8'd3) begin
      fails++; $display("FAIL to_enter3: got %0d want 3", state);
    end
    repeat (15) tick();
    checks++;
    if (state !== 8'd3) begin
      fails++; $display("FAIL to_early: got %0d want 3", state);
    end
    tick();
`ifdef SOLVER_PHASE_TIMEOUT_EN
    checks++;
    if (state !== 8'd6 || timeout !== 1'b1 || success !== 1'b0) begin
      fails++; $display("FAIL to_expire: got state=%0d to=%b succ=%b want 6 1 0", state, timeout, success);
    end
`else
    checks++;
    if (state !== 8'd3 || timeout !== 1'b0) begin
      fails++; $display("FAIL to_disabled: got state=%0d to=%b want 3 0", state, timeout);
    end
    rst = 1;
    tick();
    rst = 0;
`endif
    start = 1;
    tick();
    start = 0;
    checks++;
    if (state !== 8'd1 || timeout !== 1'b0) begin
      fails++; $display("FAIL to_restart: got state=%0d to=%b want 1 0", state, timeout);
    end
  endtask

  initial begin
    test_reset();
    test_start_setup();
    test_limit_loops();
    test_satisfied();
    test_spurious_and_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
